// File: rtl/fixed_point_lane_dot.sv
// Handshaked fixed-point dot product: LANES signed multiply-accumulates per beat over N elements,
// then optional round-half-up, arithmetic shift to the output format, and wrap or saturate.
module fixed_point_lane_dot #(
    parameter int A_WIDTH     = 16,
    parameter int A_FRAC_BITS = 14,
    parameter int B_WIDTH     = 16,
    parameter int B_FRAC_BITS = 14,
    parameter int P_WIDTH     = 16,
    parameter int P_FRAC_BITS = 14,
    parameter int N           = 3,
    parameter int LANES       = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [N*A_WIDTH-1:0]      A,
    input  logic [N*B_WIDTH-1:0]      B,
    input  logic                      round_in,
    input  logic                      sat_in,
    input  logic                      valid_in,
    output logic                      ready_in,
    output logic signed [P_WIDTH-1:0] P,
    output logic                      overflow_out,
    output logic                      valid_out,
    input  logic                      ready_out
);

    localparam int BEATS      = (N + LANES - 1) / LANES;
    localparam int PAD        = BEATS * LANES;
    localparam int SHIFT      = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS;
    localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;
    localparam int ACC_WIDTH  = A_WIDTH + B_WIDTH + $clog2(N) + 1;
    localparam int BEAT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic signed [A_WIDTH-1:0]    r_a       [PAD];
    logic signed [B_WIDTH-1:0]    r_b       [PAD];
    logic signed [A_WIDTH-1:0]    w_a_in    [PAD];
    logic signed [B_WIDTH-1:0]    w_b_in    [PAD];
    logic signed [A_WIDTH-1:0]    w_a_shift [PAD];
    logic signed [B_WIDTH-1:0]    w_b_shift [PAD];
    logic signed [PROD_WIDTH-1:0] w_prod    [LANES];

    logic [BEAT_WIDTH-1:0]        r_beat;
    logic                         r_round;
    logic                         r_sat;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [P_WIDTH-1:0]    r_p;
    logic                         r_ovf;

    logic signed [ACC_WIDTH-1:0]  w_beat_sum;
    logic signed [ACC_WIDTH-1:0]  w_final;
    logic signed [ACC_WIDTH-1:0]  w_rnd;
    logic signed [ACC_WIDTH-1:0]  w_rounded;
    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic [ACC_WIDTH-P_WIDTH:0]   w_high;
    logic signed [P_WIDTH-1:0]    w_p;
    logic                         w_ovf;
    logic                         w_beat_last;
    logic                         w_accept;
    logic                         w_last;

    // Operands are padded to a whole number of beats and shifted down LANES slots per beat,
    // so the multipliers always read slots 0..LANES-1 and the padding contributes zero.
    for (genvar i = 0; i < PAD; i++) begin : g_elem
        if (i < N) begin : g_real
            assign w_a_in[i] = A[i*A_WIDTH +: A_WIDTH];
            assign w_b_in[i] = B[i*B_WIDTH +: B_WIDTH];
        end else begin : g_pad
            assign w_a_in[i] = '0;
            assign w_b_in[i] = '0;
        end
        if (i + LANES < PAD) begin : g_shift
            assign w_a_shift[i] = r_a[i+LANES];
            assign w_b_shift[i] = r_b[i+LANES];
        end else begin : g_fill
            assign w_a_shift[i] = '0;
            assign w_b_shift[i] = '0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_prod[l] = PROD_WIDTH'(r_a[l]) * PROD_WIDTH'(r_b[l]);
    end

    always_comb begin
        w_beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_beat_sum = w_beat_sum + ACC_WIDTH'(w_prod[l]);
        end
    end

    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACC_WIDTH-1:0] HALF_LSB = ACC_WIDTH'(1) <<< (SHIFT - 1);
        assign w_rnd = r_round ? HALF_LSB : '0;
    end else begin : g_no_round
        assign w_rnd = '0;
    end

    assign w_final     = r_acc + w_beat_sum;
    assign w_rounded   = w_final + w_rnd;
    assign w_shifted   = w_rounded >>> SHIFT;
    assign w_beat_last = (r_beat == LAST_BEAT);

    // In range only when every bit from the P sign bit upward agrees.
    assign w_high = w_shifted[ACC_WIDTH-1:P_WIDTH-1];
    assign w_ovf  = !((&w_high) || !(|w_high));

    always_comb begin
        w_p = w_shifted[P_WIDTH-1:0];
        if (w_ovf && r_sat) begin
            w_p = w_shifted[ACC_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                         : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_in) w_next = ACC;
            ACC:     if (w_beat_last) w_next = DONE;
            DONE:    if (ready_out) w_next = valid_in ? ACC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready_in  = (r_state == IDLE) || ((r_state == DONE) && ready_out);
        valid_out = (r_state == DONE);
        w_accept  = valid_in && ready_in;
        w_last    = (r_state == ACC) && w_beat_last;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_a     <= '{default: '0};
            r_b     <= '{default: '0};
            r_round <= 1'b0;
            r_sat   <= 1'b0;
            r_acc   <= '0;
            r_beat  <= '0;
            r_p     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= w_a_in;
                r_b     <= w_b_in;
                r_round <= round_in;
                r_sat   <= sat_in;
                r_acc   <= '0;
                r_beat  <= '0;
            end else if (r_state == ACC) begin
                r_a    <= w_a_shift;
                r_b    <= w_b_shift;
                r_acc  <= w_final;
                r_beat <= r_beat + BEAT_WIDTH'(1);
            end
            if (w_last) begin
                r_p   <= w_p;
                r_ovf <= w_ovf;
            end
        end
    end

    assign P            = r_p;
    assign overflow_out = r_ovf;

endmodule

// File: tb/tb_fixed_point_lane_dot.sv
// Directed bench for fixed_point_lane_dot: a Q2.14 single-lane instance driven from a vector
// table plus handshake/reset sequences, and a two-lane integer instance.
module tb_fixed_point_lane_dot;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [47:0]        aIn;
    logic [47:0]        bIn;
    logic               roundIn;
    logic               satIn;
    logic               validIn;
    logic               readyIn;
    logic signed [15:0] pOut;
    logic               overflowOut;
    logic               validOut;
    logic               readyOut;

    fixed_point_lane_dot dut (
        .clk_in(clock), .rst_in(reset), .A(aIn), .B(bIn),
        .round_in(roundIn), .sat_in(satIn), .valid_in(validIn), .ready_in(readyIn),
        .P(pOut), .overflow_out(overflowOut), .valid_out(validOut), .ready_out(readyOut)
    );

    logic [23:0]       aLane;
    logic [23:0]       bLane;
    logic              roundLane;
    logic              satLane;
    logic              validInLane;
    logic              readyInLane;
    logic signed [7:0] pLane;
    logic              overflowLane;
    logic              validOutLane;
    logic              readyOutLane;

    fixed_point_lane_dot #(
        .A_WIDTH(8), .A_FRAC_BITS(0), .B_WIDTH(8), .B_FRAC_BITS(0),
        .P_WIDTH(8), .P_FRAC_BITS(0), .N(3), .LANES(2)
    ) dutLanes (
        .clk_in(clock), .rst_in(reset), .A(aLane), .B(bLane),
        .round_in(roundLane), .sat_in(satLane), .valid_in(validInLane), .ready_in(readyInLane),
        .P(pLane), .overflow_out(overflowLane), .valid_out(validOutLane), .ready_out(readyOutLane)
    );

    typedef struct {
        string              name;
        logic signed [15:0] a0, a1, a2;
        logic signed [15:0] b0, b1, b2;
        logic               rnd;
        logic               sat;
        logic signed [15:0] expP;
        logic               expOvf;
    } vec_t;

    localparam int NUM_VECS = 12;
    vec_t vecs [NUM_VECS];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mkVec(input string n, input int a0, input int a1, input int a2,
                                   input int b0, input int b1, input int b2,
                                   input logic rnd, input logic sat, input int expP, input logic expOvf);
        vec_t v;
        v.name = n;
        v.a0 = 16'(a0); v.a1 = 16'(a1); v.a2 = 16'(a2);
        v.b0 = 16'(b0); v.b1 = 16'(b1); v.b2 = 16'(b2);
        v.rnd = rnd; v.sat = sat; v.expP = 16'(expP); v.expOvf = expOvf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic driveOperands(input vec_t v);
        aIn     = {v.a2, v.a1, v.a0};
        bIn     = {v.b2, v.b1, v.b0};
        roundIn = v.rnd;
        satIn   = v.sat;
    endtask

    // Called just after a negedge; returns at the negedge following the accept edge,
    // with inputs scrambled so only captured operands and modes can matter.
    task automatic applyStimulus(input vec_t v);
        int waited;
        driveOperands(v);
        validIn = 1'b1;
        waited  = 0;
        while (!readyIn && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checkOutput({v.name, ".acceptReady"}, 32'(readyIn), 1);
        @(posedge clock);
        @(negedge clock);
        validIn = 1'b0;
        aIn     = {16'($urandom), 16'($urandom), 16'($urandom)};
        bIn     = {16'($urandom), 16'($urandom), 16'($urandom)};
        roundIn = ~roundIn;
        satIn   = ~satIn;
        checkOutput({v.name, ".busyReadyIn"}, 32'(readyIn), 0);
    endtask

    task automatic waitResult(input string name, input int expLatency,
                              input logic signed [15:0] expP, input logic expOvf);
        int cycles;
        cycles = 0;
        while (!validOut && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput({name, ".latency"}, 32'(cycles), 32'(expLatency));
        checkOutput({name, ".P"}, 32'(pOut), 32'(expP));
        checkOutput({name, ".overflow"}, 32'(overflowOut), 32'(expOvf));
    endtask

    task automatic laneOp(input string name, input logic [23:0] a, input logic [23:0] b,
                          input logic sat, input logic signed [7:0] expP, input logic expOvf);
        int cycles;
        aLane       = a;
        bLane       = b;
        satLane     = sat;
        validInLane = 1'b1;
        checkOutput({name, ".ready"}, 32'(readyInLane), 1);
        @(posedge clock);
        @(negedge clock);
        validInLane = 1'b0;
        aLane       = '1;
        bLane       = '1;
        cycles      = 0;
        while (!validOutLane && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
        checkOutput({name, ".latency"}, 32'(cycles), 2);
        checkOutput({name, ".P"}, 32'(pLane), 32'(expP));
        checkOutput({name, ".overflow"}, 32'(overflowLane), 32'(expOvf));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int   seq [3];
        logic sawValid;

        vecs[0]  = mkVec("basic",     16384, 8192, -4096, 16384, 16384, 16384, 0, 1, 20480, 0);
        vecs[1]  = mkVec("satPos",    24576, 24576, 24576, 24576, 24576, 24576, 0, 1, 32767, 1);
        vecs[2]  = mkVec("wrapPos",   24576, 24576, 24576, 24576, 24576, 24576, 0, 0, -20480, 1);
        vecs[3]  = mkVec("truncHalf", 1, 0, 0, 8192, 0, 0, 0, 1, 0, 0);
        vecs[4]  = mkVec("roundHalf", 1, 0, 0, 8192, 0, 0, 1, 1, 1, 0);
        vecs[5]  = mkVec("truncNeg",  -1, 0, 0, 8192, 0, 0, 0, 1, -1, 0);
        vecs[6]  = mkVec("roundNeg",  -1, 0, 0, 8192, 0, 0, 1, 1, 0, 0);
        vecs[7]  = mkVec("satNeg",    -32768, -32768, -32768, 24576, 24576, 24576, 0, 1, -32768, 1);
        vecs[8]  = mkVec("exactMax",  32767, 0, 0, 16384, 0, 0, 0, 1, 32767, 0);
        vecs[9]  = mkVec("roundOvfS", 32767, 1, 0, 16384, 8192, 0, 1, 1, 32767, 1);
        vecs[10] = mkVec("roundOvfW", 32767, 1, 0, 16384, 8192, 0, 1, 0, -32768, 1);
        vecs[11] = mkVec("exactMin",  -32768, 0, 0, 16384, 0, 0, 0, 1, -32768, 0);

        reset        = 1'b1;
        aIn          = '0;
        bIn          = '0;
        roundIn      = 1'b0;
        satIn        = 1'b0;
        validIn      = 1'b0;
        readyOut     = 1'b1;
        aLane        = '0;
        bLane        = '0;
        roundLane    = 1'b0;
        satLane      = 1'b0;
        validInLane  = 1'b0;
        readyOutLane = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset.P", 32'(pOut), 0);
        checkOutput("reset.overflow", 32'(overflowOut), 0);
        checkOutput("reset.validOut", 32'(validOut), 0);
        checkOutput("reset.readyIn", 32'(readyIn), 1);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            waitResult(vecs[i].name, 3, vecs[i].expP, vecs[i].expOvf);
            @(negedge clock);
            checkOutput({vecs[i].name, ".validDrop"}, 32'(validOut), 0);
        end

        // Downstream stalls with a new operation already waiting upstream.
        readyOut = 1'b0;
        applyStimulus(vecs[0]);
        waitResult("bp.first", 3, 20480, 0);
        driveOperands(vecs[4]);
        validIn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checkOutput("bp.holdP", 32'(pOut), 20480);
            checkOutput("bp.holdValid", 32'(validOut), 1);
            checkOutput("bp.readyIn", 32'(readyIn), 0);
        end
        readyOut = 1'b1;
        #1;
        checkOutput("bp.readyInRise", 32'(readyIn), 1);
        seq[0] = 4;
        seq[1] = 1;
        seq[2] = 2;
        for (int r = 0; r < 3; r++) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput("b2b.validDrop", 32'(validOut), 0);
            waitResult({"b2b.", vecs[seq[r]].name}, 3, vecs[seq[r]].expP, vecs[seq[r]].expOvf);
            if (r < 2) begin
                driveOperands(vecs[seq[r+1]]);
            end else begin
                validIn = 1'b0;
            end
        end
        @(negedge clock);
        checkOutput("b2b.idle", 32'(validOut), 0);

        // Reset after one beat of accumulation.
        applyStimulus(vecs[1]);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rstAcc.validOut", 32'(validOut), 0);
        checkOutput("rstAcc.readyIn", 32'(readyIn), 1);
        sawValid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (validOut) sawValid = 1'b1;
        end
        checkOutput("rstAcc.noValid", 32'(sawValid), 0);
        applyStimulus(vecs[0]);
        waitResult("rstAcc.next", 3, 20480, 0);
        @(negedge clock);

        // Reset while a result is held in DONE.
        readyOut = 1'b0;
        applyStimulus(vecs[2]);
        waitResult("rstDone.first", 3, -20480, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        readyOut = 1'b1;
        checkOutput("rstDone.validOut", 32'(validOut), 0);
        checkOutput("rstDone.P", 32'(pOut), 0);
        checkOutput("rstDone.overflow", 32'(overflowOut), 0);
        checkOutput("rstDone.readyIn", 32'(readyIn), 1);

        laneOp("lanes.squares", {8'd3, 8'd2, 8'd1}, {8'd3, 8'd2, 8'd1}, 1'b1, 8'sd14, 1'b0);
        laneOp("lanes.mixed", {8'hFD, 8'h02, 8'hFF}, {8'd6, 8'd5, 8'd4}, 1'b1, -8'sd12, 1'b0);
        laneOp("lanes.sat", {8'd100, 8'd100, 8'd100}, {8'd100, 8'd100, 8'd100}, 1'b1, 8'sd127, 1'b1);
        laneOp("lanes.wrap", {8'd100, 8'd100, 8'd100}, {8'd100, 8'd100, 8'd100}, 1'b0, 8'sd48, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
